// File: rtl/bram_wide_buf_pkg.sv
// Shared definitions for the MIG-side wide buffers: controller states and
// sizing helpers used by the buffer modules and their interfaces.
package bram_wide_buf_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } buf_state_e;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

  function automatic int nlanes(input int data_w, input int lane_w);
    return data_w / lane_w;
  endfunction

endpackage

// File: rtl/bram_wide_buf_if.sv
// Request/response bundle of the wide buffer: the user side drives requests
// (master), the buffer returns read data, a valid strobe and busy (slave).
interface bram_wide_buf_if
  import bram_wide_buf_pkg::*;
#(
  parameter int DATA_W = 72,
  parameter int ADDR_W = 8,
  parameter int LANE_W = 9
);
  localparam int NLANES = nlanes(DATA_W, LANE_W);

  logic              clr;
  logic [ADDR_W-1:0] addr;
  logic              en;
  logic              we;
  logic [NLANES-1:0] be;
  logic [DATA_W-1:0] wr;
  logic [DATA_W-1:0] rd;
  logic              rd_valid;
  logic              busy;

  modport master (output clr, addr, en, we, be, wr, input rd, rd_valid, busy);
  modport slave  (input clr, addr, en, we, be, wr, output rd, rd_valid, busy);
endinterface

// File: rtl/bram_wide_buf_core.sv
// Single-port RAM array with per-lane write enables and a write-first
// registered read port, written so it maps onto block RAM.
module bram_wide_buf_core
  import bram_wide_buf_pkg::*;
#(
  parameter int DATA_W = 72,
  parameter int ADDR_W = 8,
  parameter int LANE_W = 9
) (
  input  logic                                clk,
  input  logic                                en,
  input  logic                                we,
  input  logic [nlanes(DATA_W, LANE_W)-1:0]   be,
  input  logic [ADDR_W-1:0]                   addr,
  input  logic [DATA_W-1:0]                   din,
  output logic [DATA_W-1:0]                   dout
);
  localparam int NLANES = nlanes(DATA_W, LANE_W);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] dout_q;

  // Each lane either takes the new data (and forwards it) or forwards the old lane.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < NLANES; i++) begin
        if (we && be[i]) begin
          mem[addr][i*LANE_W +: LANE_W] <= din[i*LANE_W +: LANE_W];
          dout_q[i*LANE_W +: LANE_W]    <= din[i*LANE_W +: LANE_W];
        end else begin
          dout_q[i*LANE_W +: LANE_W]    <= mem[addr][i*LANE_W +: LANE_W];
        end
      end
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/bram_wide_buf.sv
// Wide block-RAM buffer: clear sequencer, request/clear address mux, valid
// pipeline and optional output register around bram_wide_buf_core.
module bram_wide_buf
  import bram_wide_buf_pkg::*;
#(
  parameter int DATA_W     = 72,
  parameter int ADDR_W     = 8,
  parameter int LANE_W     = 9,
  parameter int OUT_REG    = 1,
  parameter int INIT_CLEAR = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  bram_wide_buf_if.slave    bus
);
  localparam int NLANES = nlanes(DATA_W, LANE_W);

  if (DATA_W % LANE_W != 0) begin : g_chk_lane
    $error("bram_wide_buf: DATA_W must be a multiple of LANE_W");
  end
  if (OUT_REG != 0 && OUT_REG != 1) begin : g_chk_out_reg
    $error("bram_wide_buf: OUT_REG must be 0 or 1");
  end

  buf_state_e        state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q;
  logic              accept;
  logic              core_en;
  logic              core_we;
  logic [NLANES-1:0] core_be;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_din;
  logic [DATA_W-1:0] core_dout;
  logic              vld_p1_d;
  logic              vld_p1_q;

  // clr wins over a same-cycle request, which is then dropped.
  assign accept = bus.en && !busy_q && !bus.clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_IDLE;
      busy_q  <= (INIT_CLEAR != 0);
      cnt_q   <= '0;
    end else if (bus.clr) begin
      state_q <= ST_CLEAR;
      busy_q  <= 1'b1;
      cnt_q   <= '0;
    end else if (state_q == ST_CLEAR) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == '1) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end
    end
  end

  always_comb begin
    core_en   = accept;
    core_we   = bus.we;
    core_be   = bus.be;
    core_addr = bus.addr;
    core_din  = bus.wr;
    if (state_q == ST_CLEAR) begin
      core_en   = 1'b1;
      core_we   = 1'b1;
      core_be   = '1;
      core_addr = cnt_q;
      core_din  = '0;
    end
  end

  bram_wide_buf_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .LANE_W (LANE_W)
  ) u_core (
    .clk  (clk),
    .en   (core_en),
    .we   (core_we),
    .be   (core_be),
    .addr (core_addr),
    .din  (core_din),
    .dout (core_dout)
  );

  // ---- stage p1: RAM output register, valid only for accepted requests ----
  assign vld_p1_d = accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1_q <= 1'b0;
    else        vld_p1_q <= vld_p1_d;
  end

  // ---- stage p2: optional output register; rd holds between results ----
  if (OUT_REG != 0) begin : g_out_reg
    logic              vld_p2_d;
    logic              vld_p2_q;
    logic [DATA_W-1:0] rd_p2_d;
    logic [DATA_W-1:0] rd_p2_q;

    always_comb begin
      vld_p2_d = vld_p1_q;
      rd_p2_d  = vld_p1_q ? core_dout : rd_p2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p2_q <= 1'b0;
        rd_p2_q  <= '0;
      end else begin
        vld_p2_q <= vld_p2_d;
        rd_p2_q  <= rd_p2_d;
      end
    end

    assign bus.rd       = rd_p2_q;
    assign bus.rd_valid = vld_p2_q;
  end else begin : g_no_out_reg
    logic [DATA_W-1:0] rd_hold_d;
    logic [DATA_W-1:0] rd_hold_q;

    // The RAM register also changes on clear writes, so a hold copy keeps rd stable.
    always_comb rd_hold_d = vld_p1_q ? core_dout : rd_hold_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_hold_q <= '0;
      else        rd_hold_q <= rd_hold_d;
    end

    assign bus.rd       = rd_hold_d;
    assign bus.rd_valid = vld_p1_q;
  end

  assign bus.busy = busy_q;

endmodule
